// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending write-back counter with busy flags and issue back-pressure
module wb_scoreboard #(
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [31:0] issue_instr,
    output logic        issue_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        busy_any,
    output logic        rd_err,
    output logic        wb_err
);
    localparam logic [CNT_W-1:0] SAT = '1;

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] inc, dec;
    logic [4:0]       opcode, rd;
    logic             writes, rd_in_range, wb_in_range, tracked, fire;
    logic [CNT_W-1:0] rd_cnt, wb_cnt;
    logic             unused_bits;

    function automatic logic [CNT_W-1:0] cnt_at(input logic [4:0] a);
        cnt_at = '0;
        for (int i = 1; i < NREGS; i++)
            if (a == 5'(i)) cnt_at = cnt[i];
    endfunction

    assign opcode      = issue_instr[6:2];
    assign rd          = issue_instr[11:7];
    assign unused_bits = ^{issue_instr[31:12], issue_instr[1:0]};
    assign writes      = !(opcode == 5'b01000 || opcode == 5'b11000);
    assign rd_in_range = 32'(rd) < NREGS;
    assign wb_in_range = 32'(wb_rd) < NREGS;
    assign tracked     = writes && rd != 5'd0 && rd_in_range;
    assign rd_cnt      = cnt_at(rd);
    assign wb_cnt      = cnt_at(wb_rd);
    assign issue_ready = !(tracked && rd_cnt == SAT);
    assign fire        = issue_valid && issue_ready;
    assign rs1_busy    = cnt_at(rs1_addr) != '0;
    assign rs2_busy    = cnt_at(rs2_addr) != '0;

    // per-register increment/decrement strobes and any-pending reduction
    always_comb begin
        inc      = '0;
        dec      = '0;
        busy_any = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            inc[i]   = fire && tracked && rd == 5'(i);
            dec[i]   = wb_valid && wb_rd == 5'(i) && cnt[i] != '0;
            busy_any = busy_any || cnt[i] != '0;
        end
    end

    // pending counters; simultaneous inc and dec cancel, flush discards everything
    always_ff @(posedge clk) begin
        if (rst || flush)
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
        else begin
            cnt[0] <= '0;
            for (int i = 1; i < NREGS; i++)
                cnt[i] <= cnt[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
        end
    end

    // sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_err <= 1'b0;
            wb_err <= 1'b0;
        end else begin
            if (fire && writes && rd != 5'd0 && !rd_in_range) rd_err <= 1'b1;
            if (wb_valid && wb_rd != 5'd0 && wb_in_range && wb_cnt == '0) wb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed checks of wb_scoreboard with NREGS=16, CNT_W=2
module tb_wb_scoreboard;
  logic        clk = 1'b0;
  logic        rst, issue_valid, wb_valid, flush;
  logic [31:0] issue_instr;
  logic [4:0]  wb_rd, rs1_addr, rs2_addr;
  logic        issue_ready, rs1_busy, rs2_busy, busy_any, rd_err, wb_err;
  int          checks = 0;
  int          errors = 0;
  wb_scoreboard #(.NREGS(16), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_instr(issue_instr),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_any(busy_any), .rd_err(rd_err), .wb_err(wb_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic o, input logic e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_instr = 32'h0; wb_valid = 1'b0;
    wb_rd = 5'd0; flush = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_ready", issue_ready, 1'b1);
    chk("rst_busy_any", busy_any, 1'b0);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_wb_err", wb_err, 1'b0);
    issue_valid = 1'b1; issue_instr = 32'h00500293; rs1_addr = 5'd5; #1;
    chk("addi_same_cycle", rs1_busy, 1'b0);
    tick(); issue_valid = 1'b0; #1;
    chk("addi_next_cycle", rs1_busy, 1'b1);
    chk("addi_busy_any", busy_any, 1'b1);
    wb_valid = 1'b1; wb_rd = 5'd5;
    tick(); wb_valid = 1'b0; #1;
    chk("x5_commit_busy", rs1_busy, 1'b0);
    chk("x5_commit_any", busy_any, 1'b0);
    rs2_addr = 5'd7; issue_valid = 1'b1; issue_instr = 32'h000003A3;
    tick(); issue_instr = 32'h000003E3;
    tick(); issue_instr = 32'h00000013; #1;
    chk("x0_ready", issue_ready, 1'b1);
    tick(); issue_valid = 1'b0; #1;
    chk("store_branch_x7", rs2_busy, 1'b0);
    chk("untracked_any", busy_any, 1'b0);
    issue_valid = 1'b1; issue_instr = 32'h00000A13;
    tick(); issue_valid = 1'b0; #1;
    chk("rd20_rd_err", rd_err, 1'b1);
    chk("rd20_any", busy_any, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd20; rs1_addr = 5'd20;
    tick(); wb_valid = 1'b0; #1;
    chk("wb20_wb_err", wb_err, 1'b0);
    chk("rs20_not_busy", rs1_busy, 1'b0);
    rs1_addr = 5'd3; issue_valid = 1'b1; issue_instr = 32'h00000193;
    tick(); tick(); tick(); #1;
    chk("sat_ready", issue_ready, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd3; #1;
    chk("sat_commit_ready", issue_ready, 1'b0);
    tick(); #1;
    chk("sat_after_commit", issue_ready, 1'b1);
    issue_valid = 1'b0;
    tick(); #1;
    chk("x3_count1", rs1_busy, 1'b1);
    tick(); wb_valid = 1'b0; #1;
    chk("x3_count0", rs1_busy, 1'b0);
    chk("x3_no_wb_err", wb_err, 1'b0);
    rs1_addr = 5'd9; issue_valid = 1'b1; issue_instr = 32'h00000493;
    tick(); wb_valid = 1'b1; wb_rd = 5'd9;
    tick(); issue_valid = 1'b0; wb_valid = 1'b0; #1;
    chk("x9_inc_dec", rs1_busy, 1'b1);
    chk("x9_inc_dec_err", wb_err, 1'b0);
    wb_valid = 1'b1;
    tick(); #1;
    chk("x9_cleared", rs1_busy, 1'b0);
    tick(); wb_valid = 1'b0; #1;
    chk("x9_underflow_err", wb_err, 1'b1);
    chk("x9_no_underflow", rs1_busy, 1'b0);
    tick(); #1;
    chk("wb_err_sticky", wb_err, 1'b1);
    issue_valid = 1'b1; issue_instr = 32'h00000213;
    tick(); issue_instr = 32'h00000313;
    tick(); issue_valid = 1'b0; rs1_addr = 5'd4; rs2_addr = 5'd6; #1;
    chk("x4_pending", rs1_busy, 1'b1);
    chk("x6_pending", rs2_busy, 1'b1);
    flush = 1'b1; issue_valid = 1'b1; issue_instr = 32'h00000413;
    tick(); flush = 1'b0; issue_valid = 1'b0; rs1_addr = 5'd8; #1;
    chk("flush_any", busy_any, 1'b0);
    chk("flush_x8", rs1_busy, 1'b0);
    chk("flush_keeps_rd_err", rd_err, 1'b1);
    rs1_addr = 5'd4; issue_valid = 1'b1; issue_instr = 32'h00000213;
    tick(); tick(); issue_valid = 1'b0; #1;
    chk("x4_before_rst", rs1_busy, 1'b1);
    rst = 1'b1; wb_valid = 1'b1; wb_rd = 5'd4;
    tick(); rst = 1'b0; wb_valid = 1'b0; #1;
    chk("rst_mid_busy", rs1_busy, 1'b0);
    chk("rst_mid_any", busy_any, 1'b0);
    chk("rst_mid_rd_err", rd_err, 1'b0);
    chk("rst_mid_wb_err", wb_err, 1'b0);
    chk("rst_mid_ready", issue_ready, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Parametrised write-back tracker for the RV32 pipeline. Decodes each issuing instruction's write-back behaviour (register write enable and destination), keeps a per-register count of in-flight writes, and retires them when the write-back stage commits. It sits between decode/issue and write-back. It supplies source-operand busy flags for hazard stalls and back-pressures issue when a register's count saturates.

## Interface
Parameters:
- NREGS, 32: architectural registers tracked; 32 for RV32I, 16 for RV32E.
- CNT_W, 2: width of each per-register pending counter; at most 2^CNT_W-1 outstanding writes per register.

Ports:
- clk  in  1  clock; one clock domain, rising edge.
- rst  in  1  reset; synchronous, active-high.
- issue_valid  in  1  an instruction is presented for issue.
- issue_instr  in  32  the instruction word presented for issue.
- issue_ready  out  1  the scoreboard accepts the instruction. Issue fires on issue_valid & issue_ready.
- wb_valid  in  1  the write-back stage commits a register write this cycle.
- wb_rd  in  5  destination register of the committed write.
- flush  in  1  pipeline flush; all pending counts are discarded.
- rs1_addr  in  5  first source register to check.
- rs2_addr  in  5  second source register to check.
- rs1_busy  out  1  rs1_addr has a non-zero pending count.
- rs2_busy  out  1  rs2_addr has a non-zero pending count.
- busy_any  out  1  at least one pending count is non-zero.
- rd_err  out  1  sticky flag: an issued write targeted rd >= NREGS.
- wb_err  out  1  sticky flag: a commit arrived for a register whose count was already 0.

## Operation
Decode, combinational, from issue_instr:
- opcode = instr[6:2]; rd = instr[11:7].
- writes = 1 unless opcode is 5'b01000 (S-type) or 5'b11000 (B-type).
- tracked = writes & (rd != 0) & (rd < NREGS).

issue_ready:
- 0 when tracked and cnt[rd] equals its saturation value 2^CNT_W-1.
- 1 otherwise.
- Depends only on registered state. A same-cycle commit to that register does not raise ready.

Counter update, per register r, per clock:
- inc = issue fire & tracked & rd==r.
- dec = wb_valid & wb_rd==r & cnt[r]!=0 & r!=0 & r<NREGS.
- inc & dec: count unchanged. inc only: count + 1. dec only: count - 1.
- Register 0 is never tracked. Its count is always 0.

Commits that do not decrement:
- wb_valid with wb_rd >= NREGS is ignored.
- wb_valid with wb_rd == 0 is ignored.
- wb_valid to a register with a zero count is ignored and sets wb_err.
- Exception: if that register also has an increment that cycle, the commit is ignored, the count goes to 1, and wb_err is set.

Errors:
- Issue fire with writes & rd != 0 & rd >= NREGS sets rd_err. No counter changes.
- rd_err and wb_err stay set until rst.

flush:
- Next cycle, every count is 0.
- A same-cycle issue and a same-cycle commit are both discarded.
- Error flags are not cleared by flush. A commit to a zero count in the flush cycle still sets wb_err.

Busy outputs:
- rs1_busy = cnt[rs1_addr] != 0. rs2_busy is the same for rs2_addr.
- Addresses >= NREGS, and address 0, read as not busy.

## Timing
- Reset values: all counts 0, rs1_busy = rs2_busy = busy_any = 0, rd_err = wb_err = 0, issue_ready = 1.
- rst has priority over flush, issue and commit.
- Issue fire at edge N: busy is visible from cycle N+1. There is no same-cycle forwarding.
- Commit at edge N: busy clears from cycle N+1 if the count reaches 0.
- issue_ready, rs*_busy and busy_any are combinational from registered counts plus issue_instr / rs*_addr. The only path from input to output is through decode and the address mux.
- Saturation is a hard boundary: a count never wraps from 2^CNT_W-1 to 0, and never underflows below 0.
- Reset mid-operation: all state returns to reset values on the next edge, whatever the pending counts.

## Test plan
- Reset, then issue ADDI x5 (0x00500293), then check rs1_addr=5 -> rs1_busy=0 in the issue cycle and 1 the next cycle. Then wb_valid with wb_rd=5 -> rs1_busy=0 one cycle later, busy_any=0.
- Issue SW (opcode 0100011) and BEQ (opcode 1100011) with instr[11:7]=7 -> cnt[7] stays 0, rs2_busy for x7 = 0. Issue with rd=0 -> no busy, issue_ready=1.
- CNT_W=2: issue rd=3 three times -> issue_ready=0 for a fourth rd=3. Same cycle, commit rd=3 -> ready still 0. Next cycle ready=1 and count=2.
- Issue rd=9 and commit rd=9 in the same cycle with count=1 -> count stays 1. Commit rd=9 alone with count=0 -> wb_err=1 and stays set.
- NREGS=16: issue rd=20 -> rd_err=1, busy_any unchanged. Commit wb_rd=20 -> ignored, wb_err unchanged.
- With x4 and x6 pending, assert flush together with an issue to rd=8 -> next cycle busy_any=0 and x8 not busy. With counts non-zero, assert rst together with a commit -> all outputs at reset values.
